compact_target_encoder: RTL

Converts a 256-bit numeric mining target into the 32-bit compact difficulty word consumed by the hash validator. It scans the target one byte per cycle from the most significant byte down. It emits the exponent byte and the 3-byte mantissa in the validator's byte layout. It sits on the retarget path, between the target arithmetic and the difficulty register that feeds the validator.

---
 rtl/compact_target_encoder.sv | 103 ++++++++++
 1 files changed

// File: rtl/compact_target_encoder.sv
// Byte-serial encoder from a 256-bit mining target to the 32-bit compact difficulty word.
// The scan walks from the most significant byte down and stops at the first nonzero byte, or at byte 3.
module compact_target_encoder (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic [31:0]  difficulty,
    output logic         truncated
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [255:0] scan_reg;
    logic [4:0]   idx;
    logic         byte_hit;
    logic         scan_end;
    logic         accept;
    logic [7:0]   exponent;
    logic [23:0]  mantissa;
    logic         trunc_next;

    // The captured target is shifted left one byte per step, so byte idx is always at the top.
    assign byte_hit = |scan_reg[255:248];
    assign scan_end = (state == SCAN) && (byte_hit || (idx == 5'd3));
    assign accept   = start && (state != SCAN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (scan_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SCAN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Falling through byte 3 leaves the original bytes 2..0 just below the top byte, exactly.
    always_comb begin
        exponent   = 8'd3;
        mantissa   = scan_reg[247:224];
        trunc_next = 1'b0;
        if (byte_hit) begin
            exponent   = {3'b000, idx} + 8'd1;
            mantissa   = scan_reg[255:232];
            trunc_next = |scan_reg[231:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_reg   <= '0;
            idx        <= '0;
            difficulty <= '0;
            truncated  <= 1'b0;
        end else begin
            if (accept) begin
                scan_reg <= target;
                idx      <= 5'd31;
            end else if ((state == SCAN) && !scan_end) begin
                scan_reg <= {scan_reg[247:0], 8'h00};
                idx      <= idx - 5'd1;
            end
            if (scan_end) begin
                difficulty <= {mantissa[7:0], mantissa[15:8], mantissa[23:16], exponent};
                truncated  <= trunc_next;
            end
        end
    end

endmodule
